sha_digest_serializer: RTL and testbench

Output-side counterpart to the byte-wide message input of the SHA-256 core.
- Captures the eight 32-bit hash words when the core signals completion.
- Streams the digest out one byte at a time over a valid/ready handshake, most significant byte of hash[0] first.
- Sits directly after the SHA top level and feeds a UART, FIFO or host byte port.

---
 rtl/sha_digest_serializer.sv | 177 +++++++++++++++++
 tb/tb_sha_digest_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_digest_serializer.sv
// ---------------------------------------------------------------------------
// sha_digest_serializer
//
// Purpose:
//   Captures the SHA-256 digest words when the core raises finish_flag and
//   streams them out one byte at a time over a valid/ready handshake, most
//   significant byte of hash[0] first (big-endian).
//
// Optional build macro:
//   SHA_SER_HEX_EN - when defined, every digest nibble is sent as a lowercase
//                    ASCII hex character (high nibble first), doubling the
//                    stream length to 8*NUM_WORDS characters.
//
// Parameters:
//   NUM_WORDS   number of 32-bit digest words captured and sent (1..8)
//   WORD_W      digest word width, fixed at 32
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   finish_flag  digest-complete level from the SHA core
//   hash[8]      digest words, hash[0] is the most significant word
//   dout_ready   downstream accepts dout when high together with dout_valid
//   dout         current byte / character
//   dout_valid   dout holds a valid byte
//   dout_last    high with the final byte of the digest
//   busy         capture register owned, serialization in progress
//   overrun      sticky: a start event arrived while busy
// ---------------------------------------------------------------------------
module sha_digest_serializer #(
    parameter int NUM_WORDS = 8,
    parameter int WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              finish_flag,
    input  logic [WORD_W-1:0] hash [8],
    input  logic              dout_ready,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              busy,
    output logic              overrun
);

`ifdef SHA_SER_HEX_EN
    localparam int CNT_W   = 6;
    localparam int NUM_OUT = 8 * NUM_WORDS;
`else
    localparam int CNT_W   = 5;
    localparam int NUM_OUT = 4 * NUM_WORDS;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_finish_q;
    logic [WORD_W-1:0] r_cap [8];
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_dout;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_overrun;

    logic              w_start;
    logic              w_xfer;
    logic [CNT_W-1:0]  w_next_idx;
    logic [2:0]        w_word_idx;
    logic [WORD_W-1:0] w_shifted;
    logic [7:0]        w_next_byte;
    logic [7:0]        w_first_byte;

`ifdef SHA_SER_HEX_EN
    function automatic logic [7:0] to_hex(input logic [3:0] nib);
        to_hex = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction
`endif

    // A level held high counts once: only the 0->1 transition starts a stream.
    assign w_start    = finish_flag & ~r_finish_q;
    assign w_xfer     = r_valid & dout_ready;
    assign w_next_idx = r_cnt + 1'b1;

    // Byte that follows the one currently presented; only consumed while
    // r_cnt < LAST_IDX, so the word index always lands on a captured word.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_word_idx   = '0;
        w_shifted    = '0;
        w_next_byte  = 8'h00;
        w_first_byte = 8'h00;
`ifdef SHA_SER_HEX_EN
        w_word_idx   = w_next_idx[5:3];
        w_shifted    = r_cap[w_word_idx] << {w_next_idx[2:0], 2'b00};
        w_next_byte  = to_hex(w_shifted[31:28]);
        w_first_byte = to_hex(hash[0][31:28]);
`else
        w_word_idx   = w_next_idx[4:2];
        w_shifted    = r_cap[w_word_idx] << {w_next_idx[1:0], 3'b000};
        w_next_byte  = w_shifted[31:24];
        w_first_byte = hash[0][31:24];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_finish_q <= 1'b0;
            r_cnt      <= '0;
            r_dout     <= 8'h00;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
            // NOTE: the capture register is small and must read back as zero
            // after reset, so it is reset explicitly rather than left as
            // uninitialised storage.
            for (int i = 0; i < 8; i++) begin
                r_cap[i] <= '0;
            end
        end else begin
            r_finish_q <= finish_flag;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        for (int i = 0; i < 8; i++) begin
                            r_cap[i] <= (i < NUM_WORDS) ? hash[i] : '0;
                        end
                        r_cnt   <= '0;
                        r_dout  <= w_first_byte;
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == '0);
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Any start while the stream owns the capture register,
                    // including the cycle of the last transfer, is dropped.
                    if (w_start) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_xfer) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt  <= w_next_idx;
                            r_dout <= w_next_byte;
                            r_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sha_digest_serializer.sv
// ---------------------------------------------------------------------------
// tb_sha_digest_serializer
//
// Scoreboard bench: stimulus pushes the expected {last, byte} stream into a
// queue; a monitor on the falling edge pops and compares every transfer and
// checks that a stalled byte is held unchanged.
// ---------------------------------------------------------------------------
module tb_sha_digest_serializer;

`ifdef SHA_SER_HEX_EN
    localparam int NOUT = 64;
`else
    localparam int NOUT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        finish_flag = 1'b0;
    logic [31:0] hash_in [8];
    logic        dout_ready = 1'b1;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_last;
    logic        busy;
    logic        overrun;

    logic [31:0] abc [8];
    logic [8:0]  sb [$];
    logic [7:0]  rx_log [$];
    int          tests = 0;
    int          fails = 0;
    int          n_xfer = 0;

    sha_digest_serializer #(.NUM_WORDS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .finish_flag(finish_flag),
        .hash       (hash_in),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] lut [16];
        lut = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
        return lut[n];
    endfunction

    // Expected stream for the "abc" digest.
    task automatic push_stream();
        logic [31:0] w;
        logic [7:0]  b;
        for (int i = 0; i < NOUT; i++) begin
`ifdef SHA_SER_HEX_EN
            w = abc[i / 8];
            b = hex_char(w[31 - 4 * (i % 8) -: 4]);
`else
            w = abc[i / 4];
            b = w[31 - 8 * (i % 4) -: 8];
`endif
            sb.push_back({(i == NOUT - 1), b});
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: timeout, busy still %b after %0d cycles", name, busy, limit);
    endtask

    task automatic wait_xfers(input string name, input int base, input int n, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            if (n_xfer - base >= n) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: timeout, %0d transfers seen, %0d wanted", name, n_xfer - base, n);
    endtask

    // Monitor: compares every accepted byte and checks stall stability.
    initial begin
        logic [8:0] held;
        logic [8:0] exp;
        bit         stall_pending;
        stall_pending = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_pending = 0;
            end else begin
                if (dout_valid && stall_pending)
                    check("stall_hold", {23'h0, dout_last, dout}, {23'h0, held});
                stall_pending = 0;
                if (dout_valid && dout_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %h, expected no transfer", dout);
                    end else begin
                        exp = sb.pop_front();
                        check("stream_byte", {23'h0, dout_last, dout}, {23'h0, exp});
                    end
                    rx_log.push_back(dout);
                    n_xfer++;
                end else if (dout_valid) begin
                    held = {dout_last, dout};
                    stall_pending = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        int l0;
        bit rp [4];
        logic [7:0] head [5];
        logic [7:0] tail [2];
        rp = '{1'b1, 1'b0, 1'b0, 1'b1};
        abc = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2220,
                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
`ifdef SHA_SER_HEX_EN
        head = '{8'h62, 8'h61, 8'h37, 8'h38, 8'h31};
        tail = '{8'h61, 8'h64};
`else
        head = '{8'hba, 8'h78, 8'h16, 8'hbf, 8'h8f};
        tail = '{8'h15, 8'had};
`endif
        for (int i = 0; i < 8; i++) hash_in[i] = abc[i];

        // Reset state.
        #12;
        check("rst_dout", {24'h0, dout}, 32'h0);
        check("rst_valid", {31'h0, dout_valid}, 32'h0);
        check("rst_last", {31'h0, dout_last}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: "abc" digest, ready held high; exact cycle timing.
        push_stream();
        finish_flag = 1'b1;
        @(posedge clk); #1;
        check("t1_busy_after_start", {31'h0, busy}, 32'h1);
        check("t1_valid_after_start", {31'h0, dout_valid}, 32'h1);
        check("t1_first_byte", {24'h0, dout}, {24'h0, head[0]});
        repeat (NOUT - 1) @(posedge clk);
        #1;
        check("t1_last_flag", {31'h0, dout_last}, 32'h1);
        check("t1_busy_on_last", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        check("t1_busy_fell", {31'h0, busy}, 32'h0);
        check("t1_valid_fell", {31'h0, dout_valid}, 32'h0);
        check("t1_last_fell", {31'h0, dout_last}, 32'h0);
        check("t1_dout_held", {24'h0, dout}, {24'h0, tail[1]});
        check("t1_count", rx_log.size(), NOUT);
        for (int i = 0; i < 5; i++) check("t1_head", {24'h0, rx_log[i]}, {24'h0, head[i]});
        check("t1_tail0", {24'h0, rx_log[NOUT - 2]}, {24'h0, tail[0]});
        check("t1_tail1", {24'h0, rx_log[NOUT - 1]}, {24'h0, tail[1]});
        finish_flag = 1'b0;
        @(posedge clk); #1;

        // 2: backpressure 1,0,0,1.
        push_stream();
        x0 = n_xfer;
        finish_flag = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            dout_ready = rp[c % 4];
            if (c > 2 && !busy) break;
        end
        check("t2_transfers", n_xfer - x0, NOUT);
        check("t2_busy_done", {31'h0, busy}, 32'h0);
        finish_flag = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk); #1;

        // 3: finish_flag held high for 100 cycles.
        push_stream();
        x0 = n_xfer;
        finish_flag = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("t3_transfers", n_xfer - x0, NOUT);
        check("t3_busy", {31'h0, busy}, 32'h0);
        check("t3_overrun", {31'h0, overrun}, 32'h0);
        check("t3_sb_empty", sb.size(), 0);
        finish_flag = 1'b0;
        @(posedge clk); #1;

        // 4: overrun at byte 10 with hash changed to all ones.
        push_stream();
        x0 = n_xfer;
        finish_flag = 1'b1;
        wait_xfers("t4_reach_10", x0, 10, 200);
        finish_flag = 1'b0;
        for (int i = 0; i < 8; i++) hash_in[i] = 32'hffffffff;
        @(posedge clk); #1;
        finish_flag = 1'b1;
        @(posedge clk); #1;
        check("t4_overrun_set", {31'h0, overrun}, 32'h1);
        check("t4_busy_during", {31'h0, busy}, 32'h1);
        wait_idle("t4_idle", 200);
        check("t4_transfers", n_xfer - x0, NOUT);
        check("t4_overrun_sticky", {31'h0, overrun}, 32'h1);
        finish_flag = 1'b0;
        for (int i = 0; i < 8; i++) hash_in[i] = abc[i];
        repeat (3) @(posedge clk);
        #1;
        check("t4_overrun_still", {31'h0, overrun}, 32'h1);

        // 5: reset mid-stream, then restart from byte 0 with flag high.
        push_stream();
        x0 = n_xfer;
        finish_flag = 1'b1;
        wait_xfers("t5_reach_5", x0, 5, 200);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_valid", {31'h0, dout_valid}, 32'h0);
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        check("t5_rst_dout", {24'h0, dout}, 32'h0);
        check("t5_rst_last", {31'h0, dout_last}, 32'h0);
        check("t5_rst_overrun", {31'h0, overrun}, 32'h0);
        sb.delete();
        @(posedge clk); #1;
        push_stream();
        l0 = rx_log.size();
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_restart_busy", {31'h0, busy}, 32'h1);
        check("t5_restart_byte0", {24'h0, dout}, {24'h0, head[0]});
        wait_idle("t5_idle", 200);
        check("t5_restart_count", rx_log.size() - l0, NOUT);
        if (rx_log.size() > l0)
            check("t5_first_logged", {24'h0, rx_log[l0]}, {24'h0, head[0]});
        finish_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
